// File: rtl/fa_cell.sv
// fa_cell: registered WIDTH-bit full-adder slice for ripple-carry chains.
// Computes {cout, sum} = a + b + cin and presents it one clock after a valid
// input. Inter-slice carries are registered, so chained slices must be fed
// with operands skewed by one cycle per slice.
// Optional feature macro: FA_CELL_PG_EN adds registered propagate (p = a ^ b)
// and generate (g = a & b) outputs for external carry-lookahead logic.

module fa_cell #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef FA_CELL_PG_EN
    output logic             out_valid,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g
`else
    output logic             out_valid
`endif
);

    // Full-width result: the extra top bit is the carry-out, so nothing is
    // truncated before the carry is taken.
    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Result registers: reset clears everything and wins over in_valid; a
    // valid input loads a new result, otherwise the last result is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= full_sum[WIDTH-1:0];
                cout <= full_sum[WIDTH];
            end
        end
    end

`ifdef FA_CELL_PG_EN
    // Propagate/generate registers follow the same load/hold/reset rules as sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            g <= '0;
        end else if (in_valid) begin
            p <= a ^ b;
            g <= a & b;
        end
    end
`endif

endmodule

// File: tb/tb_fa_cell.sv
// tb_fa_cell: directed self-checking bench for fa_cell.
// Drives a WIDTH=1 and a WIDTH=4 instance from the same clock, reset and
// in_valid, and compares their outputs against hand-computed constants.
// Build with FA_CELL_PG_EN defined to also exercise the p/g outputs.

module tb_fa_cell;

    logic       clk;
    logic       rst;
    logic       in_valid;

    logic       a1, b1, cin1;
    logic       sum1, cout1, out_valid1;

    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4, out_valid4;

`ifdef FA_CELL_PG_EN
    logic       p1, g1;
    logic [3:0] p4, g4;
`endif

    int checkCount;
    int failCount;

    // Expected WIDTH=1 results indexed by {a, b, cin}.
    logic [7:0] expSum1  = 8'b10010110;
    logic [7:0] expCout1 = 8'b11101000;

    fa_cell #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .in_valid  (in_valid),
        .sum       (sum1),
        .cout      (cout1),
`ifdef FA_CELL_PG_EN
        .out_valid (out_valid1),
        .p         (p1),
        .g         (g1)
`else
        .out_valid (out_valid1)
`endif
    );

    fa_cell #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .in_valid  (in_valid),
        .sum       (sum4),
        .cout      (cout4),
`ifdef FA_CELL_PG_EN
        .out_valid (out_valid4),
        .p         (p4),
        .g         (g4)
`else
        .out_valid (out_valid4)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic ia1, input logic ib1, input logic ic1,
                                 input logic [3:0] ia4, input logic [3:0] ib4,
                                 input logic ic4);
        rst      = r;
        in_valid = v;
        a1       = ia1;
        b1       = ib1;
        cin1     = ic1;
        a4       = ia4;
        b4       = ib4;
        cin4     = ic4;
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        logic [2:0] vec;
        checkCount = 0;
        failCount  = 0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        checkOutput("reset_sum1", 64'(sum1), 64'd0);
        checkOutput("reset_cout1", 64'(cout1), 64'd0);
        checkOutput("reset_valid1", 64'(out_valid1), 64'd0);
        checkOutput("reset_sum4", 64'(sum4), 64'd0);
        checkOutput("reset_valid4", 64'(out_valid4), 64'd0);
`ifdef FA_CELL_PG_EN
        checkOutput("reset_p1", 64'(p1), 64'd0);
        checkOutput("reset_g1", 64'(g1), 64'd0);
`endif

        // WIDTH=1 exhaustive, back-to-back
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            applyStimulus(1'b0, 1'b1, vec[2], vec[1], vec[0], 4'h0, 4'h0, 1'b0);
            checkOutput($sformatf("exh_sum_%0d", i), 64'(sum1), 64'(expSum1[i]));
            checkOutput($sformatf("exh_cout_%0d", i), 64'(cout1), 64'(expCout1[i]));
            checkOutput($sformatf("exh_valid_%0d", i), 64'(out_valid1), 64'd1);
        end

        // WIDTH=4 carry ripple vectors
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0);
        checkOutput("w4_ff_sum", 64'(sum4), 64'b1110);
        checkOutput("w4_ff_cout", 64'(cout4), 64'd1);
        checkOutput("w4_ff_valid", 64'(out_valid4), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0100, 1'b0);
        checkOutput("w4_26_sum", 64'(sum4), 64'b0110);
        checkOutput("w4_26_cout", 64'(cout4), 64'd0);
        checkOutput("w4_26_valid", 64'(out_valid4), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b1010, 1'b1);
        checkOutput("w4_5a1_sum", 64'(sum4), 64'b0000);
        checkOutput("w4_5a1_cout", 64'(cout4), 64'd1);

        // Hold: one valid input followed by three idle cycles with new operands
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0);
        checkOutput("hold_load_sum1", 64'(sum1), 64'd0);
        checkOutput("hold_load_cout1", 64'(cout1), 64'd1);
        checkOutput("hold_load_valid1", 64'(out_valid1), 64'd1);
        checkOutput("hold_load_sum4", 64'(sum4), 64'b0000);
        checkOutput("hold_load_cout4", 64'(cout4), 64'd1);
`ifdef FA_CELL_PG_EN
        checkOutput("pg_11_p1", 64'(p1), 64'd0);
        checkOutput("pg_11_g1", 64'(g1), 64'd1);
        checkOutput("pg_f1_p4", 64'(p4), 64'b1110);
        checkOutput("pg_f1_g4", 64'(g4), 64'b0001);
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0001, 1'b1);
            checkOutput($sformatf("hold_sum1_%0d", i), 64'(sum1), 64'd0);
            checkOutput($sformatf("hold_cout1_%0d", i), 64'(cout1), 64'd1);
            checkOutput($sformatf("hold_valid1_%0d", i), 64'(out_valid1), 64'd0);
            checkOutput($sformatf("hold_sum4_%0d", i), 64'(sum4), 64'b0000);
            checkOutput($sformatf("hold_cout4_%0d", i), 64'(cout4), 64'd1);
            checkOutput($sformatf("hold_valid4_%0d", i), 64'(out_valid4), 64'd0);
`ifdef FA_CELL_PG_EN
            checkOutput($sformatf("hold_g1_%0d", i), 64'(g1), 64'd1);
`endif
        end

        // Load a nonzero result so the following reset has something to clear
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0001, 1'b0);
        checkOutput("p10_sum1", 64'(sum1), 64'd1);
        checkOutput("p10_cout1", 64'(cout1), 64'd0);
        checkOutput("p10_sum4", 64'(sum4), 64'b0100);
`ifdef FA_CELL_PG_EN
        checkOutput("pg_10_p1", 64'(p1), 64'd1);
        checkOutput("pg_10_g1", 64'(g1), 64'd0);
`endif

        // Reset priority over a simultaneous valid input
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        checkOutput("rprio_sum1", 64'(sum1), 64'd0);
        checkOutput("rprio_cout1", 64'(cout1), 64'd0);
        checkOutput("rprio_valid1", 64'(out_valid1), 64'd0);
        checkOutput("rprio_sum4", 64'(sum4), 64'd0);
        checkOutput("rprio_cout4", 64'(cout4), 64'd0);
`ifdef FA_CELL_PG_EN
        checkOutput("rprio_p1", 64'(p1), 64'd0);
        checkOutput("rprio_g1", 64'(g1), 64'd0);
`endif

        // Mid-stream reset
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 4'b0001, 1'b1);
        checkOutput("mid_load_sum1", 64'(sum1), 64'd1);
        checkOutput("mid_load_cout1", 64'(cout1), 64'd1);
        checkOutput("mid_load_valid1", 64'(out_valid1), 64'd1);
        checkOutput("mid_load_sum4", 64'(sum4), 64'b1001);
        checkOutput("mid_load_cout4", 64'(cout4), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        checkOutput("mid_rst_sum1", 64'(sum1), 64'd0);
        checkOutput("mid_rst_cout1", 64'(cout1), 64'd0);
        checkOutput("mid_rst_valid1", 64'(out_valid1), 64'd0);
        checkOutput("mid_rst_sum4", 64'(sum4), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b0011, 1'b0);
        checkOutput("mid_rel_sum1", 64'(sum1), 64'd1);
        checkOutput("mid_rel_cout1", 64'(cout1), 64'd0);
        checkOutput("mid_rel_valid1", 64'(out_valid1), 64'd1);
        checkOutput("mid_rel_sum4", 64'(sum4), 64'b1100);
        checkOutput("mid_rel_cout4", 64'(cout4), 64'd0);
        checkOutput("mid_rel_valid4", 64'(out_valid4), 64'd1);

        // Return to idle: out_valid must drop
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        checkOutput("idle_valid1", 64'(out_valid1), 64'd0);
        checkOutput("idle_sum4", 64'(sum4), 64'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
